instruction_encoder: RTL
========================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have the ports below. Clocking is one clock; reset is synchronous, active-high.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_class  input  4  0 register_arith, 1 immediate_arith, 2 load, 3 store, 4 branch, 5 immediate_jump, 6 register_jump, 7 load_upper, 8 load_upper_pc, 9 environment; 10-15 invalid
- in_register_1  input  5  rs1
- in_register_2  input  5  rs2
- in_write_register  input  5  rd
- in_funct_7  input  7  funct7 (R-type; immediate shifts)
- in_funct_3  input  3  funct3
- in_immediate  input  32  byte-offset or upper immediate
- out_valid  output  1  FIFO head valid
- out_ready  input  1  head consumed when out_valid && out_ready
- out_instruction  output  32  encoded RV32I word at head
- out_error  output  1  error flag stored with head entry
- encoded_count  output  16  accepted-request counter

Function
REQ-002 SHALL encode each accepted request combinationally and write {instruction, error} into a 2-entry FIFO in the acceptance cycle.
REQ-003 SHALL present an entry on out_valid the cycle after acceptance when the FIFO was empty (latency 1); no input-to-output bypass.
REQ-004 SHALL drive in_ready = (occupancy < 2), independent of out_ready; a full FIFO with a simultaneous pop SHALL NOT accept that cycle.
REQ-005 SHALL support simultaneous push and pop at occupancy 1, leaving occupancy 1 and ordering strictly FIFO.
REQ-006 SHALL hold out_instruction/out_error stable while out_valid && !out_ready.
REQ-007 SHALL place opcode[6:0] by class: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
REQ-008 SHALL place rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25] only for formats using them; unused fields SHALL be zero.
REQ-009 I-type (classes 1, 2, 6, 9) SHALL place imm[11:0] at [31:20]. Exception: class 1 with funct3 1 or 5 SHALL place imm[4:0] at [24:20] and funct7 at [31:25].
REQ-010 S-type SHALL place imm[11:5] at [31:25] and imm[4:0] at [11:7].
REQ-011 B-type SHALL place imm[12] at [31], imm[10:5] at [30:25], imm[4:1] at [11:8], and imm[11] at [7].
REQ-012 J-type SHALL place imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], and imm[19:12] at [19:12].
REQ-013 U-type SHALL place imm[31:12] at [31:12].
REQ-014 An invalid in_class SHALL enqueue 32'h00000013 with out_error=1.
REQ-015 encoded_count SHALL increment by 1 per accepted request, including error entries, and wrap 16'hFFFF to 0.

Reset
REQ-016 When rst is high at a clock edge: FIFO empties, out_valid=0, out_error=0, out_instruction=0, encoded_count=0, in_ready=1 the following cycle.
REQ-017 When rst is high, requests presented that cycle SHALL be discarded and in-flight entries dropped.

Configuration
REQ-018 Range checking SHALL be enabled by macro ENCODER_RANGE_CHECK_EN.
- With the macro defined, out_error=1 when any of the following holds:
  - I/S immediate is not a sign-extended 12-bit value;
  - shift amount exceeds 31;
  - B immediate is not a sign-extended 13-bit value, or imm[0]=1;
  - J immediate is not a sign-extended 21-bit value, or imm[0]=1;
  - U immediate has imm[11:0]≠0.
- With the macro defined, the encoded word SHALL still use the truncated fields.
- Without the macro, fields are truncated silently and out_error is asserted only by REQ-014.

Verification
REQ-019 class 1, rd=1, rs1=0, funct3=0, imm=5 -> out_instruction=0x00500093, out_error=0, one cycle later.
REQ-020 class 4, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463; class 7, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-021 class 1, rd=3, rs1=4, funct3=5, funct7=0x20, imm=7 -> 0x40725193.
REQ-022 out_ready=0, three back-to-back requests -> in_ready low after the second, third held; raising out_ready drains entries in order, and the third is accepted the cycle after the first pop.
REQ-023 class 5, imm=3 -> out_error=1 with ENCODER_RANGE_CHECK_EN, 0 without; in_class=12 -> 0x00000013, out_error=1 in both builds.
REQ-024 rst asserted with 2 entries queued and in_valid high -> next cycle out_valid=0, encoded_count=0, in_ready=1, and neither queued entry nor new request ever appears.

Source files
------------

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder feeding a 2-entry output FIFO, with registered head and request counter.
// Optional immediate range checking is compiled in with `define ENCODER_RANGE_CHECK_EN.
module instruction_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_class,
   input  logic [4:0]  in_register_1,
   input  logic [4:0]  in_register_2,
   input  logic [4:0]  in_write_register,
   input  logic [6:0]  in_funct_7,
   input  logic [2:0]  in_funct_3,
   input  logic [31:0] in_immediate,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instruction,
   output logic        out_error,
   output logic [15:0] encoded_count
);

   logic [31:0] enc_word;
   logic        enc_err;
   logic [31:0] mem_instr [2];
   logic        mem_err   [2];
   logic [1:0]  count;
   logic        wr_ptr;
   logic        rd_ptr;
   logic        push;
   logic        pop;

`ifdef ENCODER_RANGE_CHECK_EN
   // True when v is representable as a sign-extended value of the given width.
   function automatic logic sext_fits(input logic signed [31:0] v, input int unsigned bits);
      logic signed [31:0] hi;
      hi = v >>> (bits - 1);
      return (hi == 32'sd0) || (hi == -32'sd1);
   endfunction
`endif

   wire logic [31:0] imm = in_immediate;
   wire logic [4:0]  rs1 = in_register_1;
   wire logic [4:0]  rs2 = in_register_2;
   wire logic [4:0]  rd  = in_write_register;
   wire logic [2:0]  f3  = in_funct_3;
   wire logic [6:0]  f7  = in_funct_7;

   // Stage p0: combinational encode of the request.
   always_comb begin
      enc_word = '0;
      enc_err  = 1'b0;
      case (in_class)
         4'd0: enc_word = {f7, rs2, rs1, f3, rd, 7'b0110011};
         4'd1: begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
               enc_word = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
`ifdef ENCODER_RANGE_CHECK_EN
               enc_err  = (imm[31:5] != '0);
`endif
            end else begin
               enc_word = {imm[11:0], rs1, f3, rd, 7'b0010011};
`ifdef ENCODER_RANGE_CHECK_EN
               enc_err  = !sext_fits(imm, 12);
`endif
            end
         end
         4'd2, 4'd6, 4'd9: begin
            enc_word = {imm[11:0], rs1, f3, rd, 7'b0000000};
            enc_word[6:0] = (in_class == 4'd2) ? 7'b0000011 :
                            (in_class == 4'd6) ? 7'b1100111 : 7'b1110011;
`ifdef ENCODER_RANGE_CHECK_EN
            enc_err = !sext_fits(imm, 12);
`endif
         end
         4'd3: begin
            enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
`ifdef ENCODER_RANGE_CHECK_EN
            enc_err  = !sext_fits(imm, 12);
`endif
         end
         4'd4: begin
            enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
`ifdef ENCODER_RANGE_CHECK_EN
            enc_err  = !sext_fits(imm, 13) || imm[0];
`endif
         end
         4'd5: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
`ifdef ENCODER_RANGE_CHECK_EN
            enc_err  = !sext_fits(imm, 21) || imm[0];
`endif
         end
         4'd7, 4'd8: begin
            enc_word = {imm[31:12], rd, (in_class == 4'd7) ? 7'b0110111 : 7'b0010111};
`ifdef ENCODER_RANGE_CHECK_EN
            enc_err  = (imm[11:0] != '0);
`endif
         end
         default: begin
            enc_word = 32'h0000_0013;
            enc_err  = 1'b1;
         end
      endcase
   end

   assign in_ready = (count < 2'd2);
   assign push     = in_valid && in_ready;
   assign out_valid = (count != 2'd0);
   assign pop      = out_valid && out_ready;

   // Stage p1: FIFO control; storage is left unreset because the head is gated by out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         count         <= 2'd0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         encoded_count <= 16'd0;
      end else begin
         if (push) begin
            wr_ptr        <= ~wr_ptr;
            encoded_count <= encoded_count + 16'd1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= enc_word;
         mem_err[wr_ptr]   <= enc_err;
      end
   end

   assign out_instruction = out_valid ? mem_instr[rd_ptr] : 32'd0;
   assign out_error       = out_valid ? mem_err[rd_ptr]   : 1'b0;

endmodule
